// File: rtl/router_pkg.sv
// Shared router definitions: arbiter FSM encoding and the default burst length.
// Also used by router_controller, so keep these names stable.
package router_pkg;

  // Default number of words moved per granted burst.
  localparam int BURST_LEN_DEFAULT = 19;

  // Memory arbiter FSM states.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_GNT   = 3'd1,
    RD_BURST = 3'd2,
    WR_GNT   = 3'd3,
    WR_BURST = 3'd4
  } arb_state_t;

  // The arbiter reports busy in every state except IDLE.
  function automatic logic state_is_busy(input arb_state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/router_mem_arbiter_if.sv
// Bundle of request/grant, stream and memory-port signals around the router
// memory arbiter.
//
// Handshake semantics:
//   - read_req/write_req are level requests. They are only looked at while the
//     arbiter is idle and are answered by a one-cycle read_gnt/write_gnt pulse.
//     addr is captured in the same cycle the request is accepted.
//   - rd_ready is a credit-style gate: high means the consumer can still take
//     at least two more words, so one read can be issued. rd_valid follows an
//     issued read by exactly one cycle and is never back-pressured.
//   - wr_valid has no ready partner: during a write burst every cycle with
//     wr_valid=1 writes wr_data to memory; outside a write burst it is ignored.
//   - The memory has a fixed one-cycle read latency (mem_rdata follows a
//     mem_en=1, mem_we=0 cycle).
interface router_mem_arbiter_if #(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH        = 10
);

  logic                         read_req;
  logic                         write_req;
  logic [ADDR_WIDTH-1:0]        addr;
  logic                         read_gnt;
  logic                         write_gnt;
  logic                         busy;

  logic                         rd_ready;
  logic [AURORA_DATA_WIDTH-1:0] rd_data;
  logic                         rd_valid;
  logic                         wr_valid;
  logic [AURORA_DATA_WIDTH-1:0] wr_data;

  logic                         mem_en;
  logic                         mem_we;
  logic [ADDR_WIDTH-1:0]        mem_addr;
  logic [AURORA_DATA_WIDTH-1:0] mem_wdata;
  logic [AURORA_DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side.
  modport master (
    input  read_req, write_req, addr, rd_ready, wr_valid, wr_data, mem_rdata,
    output read_gnt, write_gnt, busy, rd_data, rd_valid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Controller / stream / memory side.
  modport slave (
    output read_req, write_req, addr, rd_ready, wr_valid, wr_data, mem_rdata,
    input  read_gnt, write_gnt, busy, rd_data, rd_valid,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/router_rr_pick.sv
// Two-way round-robin selector between read and write requests. When both
// requests are present the direction not served last wins; after reset the
// "last served" flag points at write so that read wins the first tie.
module router_rr_pick (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_rd,
  input  logic req_wr,
  output logic pick_rd,
  output logic pick_wr
);

  logic last_wr;

  // Select a direction; only one pick can be high, and only when enabled.
  always_comb begin
    pick_rd = 1'b0;
    pick_wr = 1'b0;
    if (en) begin
      if (req_rd && req_wr) begin
        pick_rd = last_wr;
        pick_wr = !last_wr;
      end else begin
        pick_rd = req_rd;
        pick_wr = req_wr;
      end
    end
  end

  // Remember which direction was granted most recently.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr <= 1'b1;
    end else if (pick_rd) begin
      last_wr <= 1'b0;
    end else if (pick_wr) begin
      last_wr <= 1'b1;
    end
  end

endmodule

// File: rtl/router_mem_arbiter.sv
// Router memory arbiter: grants read or write bursts of BURST_LEN words to the
// router controller and sequences the single-port memory. Reads stream out
// toward input port 0, writes come in from output port 0. Addresses wrap
// modulo 2^ADDR_WIDTH. BURST_LEN must be in 1..2^ADDR_WIDTH.
module router_mem_arbiter
  import router_pkg::*;
#(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH        = 10,
  parameter int BURST_LEN         = BURST_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  router_mem_arbiter_if.master bus,
  output arb_state_t           dbg_state
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BL_FULL = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BL_LAST = CNT_W'(BURST_LEN - 1);

  arb_state_t                   state;
  arb_state_t                   state_nxt;
  logic [ADDR_WIDTH-1:0]        base_addr;
  logic [CNT_W-1:0]             issued;
  logic [CNT_W-1:0]             written;
  logic                         rd_valid_q;
  logic [ADDR_WIDTH-1:0]        addr_hold;
  logic [AURORA_DATA_WIDTH-1:0] wdata_hold;

  logic                         pick_rd;
  logic                         pick_wr;
  logic                         rd_issue;
  logic                         wr_issue;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic [ADDR_WIDTH-1:0]        wr_addr;

  router_rr_pick u_rr_pick (
    .clk     (clk),
    .rst     (rst),
    .en      (state == IDLE),
    .req_rd  (bus.read_req),
    .req_wr  (bus.write_req),
    .pick_rd (pick_rd),
    .pick_wr (pick_wr)
  );

  // A word moves on the memory port only inside its own burst state.
  always_comb begin
    rd_issue = (state == RD_BURST) && bus.rd_ready && (issued < BL_FULL);
    wr_issue = (state == WR_BURST) && bus.wr_valid && (written < BL_FULL);
    rd_addr  = base_addr + ADDR_WIDTH'(issued);
    wr_addr  = base_addr + ADDR_WIDTH'(written);
  end

  // Next-state logic. A read burst ends when its last word is on rd_valid
  // (all words issued and one still landing); a write burst ends on its
  // last write.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pick_rd) begin
          state_nxt = RD_GNT;
        end else if (pick_wr) begin
          state_nxt = WR_GNT;
        end
      end
      RD_GNT:   state_nxt = RD_BURST;
      WR_GNT:   state_nxt = WR_BURST;
      RD_BURST: begin
        if (rd_valid_q && (issued == BL_FULL)) begin
          state_nxt = IDLE;
        end
      end
      WR_BURST: begin
        if (wr_issue && (written == BL_LAST)) begin
          state_nxt = IDLE;
        end
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst bookkeeping: base address and counters captured on leaving IDLE,
  // read-return tracking, and the held values of the memory address/data bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr  <= '0;
      issued     <= '0;
      written    <= '0;
      rd_valid_q <= 1'b0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      rd_valid_q <= rd_issue;
      if ((state == IDLE) && (state_nxt != IDLE)) begin
        base_addr <= bus.addr;
        issued    <= '0;
        written   <= '0;
      end
      if (rd_issue) begin
        issued    <= issued + CNT_W'(1);
        addr_hold <= rd_addr;
      end
      if (wr_issue) begin
        written    <= written + CNT_W'(1);
        addr_hold  <= wr_addr;
        wdata_hold <= bus.wr_data;
      end
    end
  end

  // Drive grants, status, read stream and memory port; the memory address and
  // write data hold their last issued values between accesses.
  always_comb begin
    bus.read_gnt  = (state == RD_GNT);
    bus.write_gnt = (state == WR_GNT);
    bus.busy      = state_is_busy(state);
    bus.rd_valid  = rd_valid_q;
    bus.rd_data   = rd_valid_q ? bus.mem_rdata : '0;
    bus.mem_en    = rd_issue || wr_issue;
    bus.mem_we    = wr_issue;
    bus.mem_addr  = addr_hold;
    if (rd_issue) begin
      bus.mem_addr = rd_addr;
    end else if (wr_issue) begin
      bus.mem_addr = wr_addr;
    end
    bus.mem_wdata = wr_issue ? bus.wr_data : wdata_hold;
    dbg_state     = state;
  end

endmodule

// File: tb/tb_router_mem_arbiter.sv
// Bench for router_mem_arbiter: a default-parameter instance plus a
// BURST_LEN=1 instance, each with a behavioural one-cycle-latency memory
// that returns an address-derived pattern.
module tb_router_mem_arbiter;
  import router_pkg::*;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int BL = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_mem_arbiter_if #(.AURORA_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus  ();
  router_mem_arbiter_if #(.AURORA_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  arb_state_t dbg_state;
  arb_state_t dbg_state1;

  router_mem_arbiter #(.AURORA_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  router_mem_arbiter #(.AURORA_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus1),
    .dbg_state (dbg_state1)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {16'hBEEF, 6'd0, a, 16'h1234, 6'd0, a};
  endfunction

  // Memory models: read data appears one cycle after a read access.
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= pat(bus.mem_addr);
  end
  always @(posedge clk) begin
    if (bus1.mem_en && !bus1.mem_we) bus1.mem_rdata <= pat(bus1.mem_addr);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.read_req   = 1'b0; bus.write_req  = 1'b0; bus.addr  = '0;
    bus.rd_ready   = 1'b0; bus.wr_valid   = 1'b0; bus.wr_data = '0;
    bus1.read_req  = 1'b0; bus1.write_req = 1'b0; bus1.addr = '0;
    bus1.rd_ready  = 1'b0; bus1.wr_valid  = 1'b0; bus1.wr_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.busy, bus.read_gnt, bus.write_gnt, bus.rd_valid, bus.mem_en, bus.mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {bus.busy, bus.read_gnt, bus.write_gnt, bus.rd_valid, bus.mem_en, bus.mem_we});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.rd_data !== '0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h wdata=%h rdata=%h want all 0",
               bus.mem_addr, bus.mem_wdata, bus.rd_data);
    end
    checks++;
    if (dbg_state !== IDLE || dbg_state1 !== IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d/%0d want IDLE", dbg_state, dbg_state1);
    end
  endtask

  task automatic test_read_burst();
    int gnt_cyc, gnt_cnt, rd_cnt, last_rd_cyc, idle_cyc;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    do_reset();
    gnt_cyc = -1; gnt_cnt = 0; rd_cnt = 0; last_rd_cyc = -1; idle_cyc = -1;
    for (int i = 0; i < BL; i++) begin
      exp_addr_q.push_back(AW'(32'h010 + i));
      exp_q.push_back(pat(AW'(32'h010 + i)));
    end
    for (int cyc = 1; cyc <= 60 && idle_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.read_req = 1'b1; bus.addr = 10'h010; bus.rd_ready = 1'b1;
      end
      #1;
      if (bus.read_gnt) begin
        gnt_cnt++;
        if (gnt_cyc < 0) gnt_cyc = cyc;
        bus.read_req = 1'b0;
      end
      if (bus.mem_en) begin
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
        checks++;
        if ({bus.mem_we, bus.mem_addr} !== {1'b0, exp_a}) begin
          errors++;
          $display("FAIL rd_issue cyc %0d got we=%b addr=%h want we=0 addr=%h",
                   cyc, bus.mem_we, bus.mem_addr, exp_a);
        end
      end
      if (bus.rd_valid) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        rd_cnt++;
        last_rd_cyc = cyc;
        checks++;
        if (bus.rd_data !== exp_d) begin
          errors++;
          $display("FAIL rd_data cyc %0d got %h want %h", cyc, bus.rd_data, exp_d);
        end
      end
      if (rd_cnt == BL && !bus.busy) idle_cyc = cyc;
    end
    checks++;
    if (gnt_cyc != 2 || gnt_cnt != 1) begin
      errors++;
      $display("FAIL rd_gnt got cyc=%0d pulses=%0d want cyc=2 pulses=1", gnt_cyc, gnt_cnt);
    end
    checks++;
    if (rd_cnt != BL || idle_cyc != last_rd_cyc + 1 || idle_cyc < 0) begin
      errors++;
      $display("FAIL rd_done got words=%0d idle_cyc=%0d last_rd=%0d want words=%0d idle=last+1",
               rd_cnt, idle_cyc, last_rd_cyc, BL);
    end
    checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL rd_leftover got %0d/%0d pending want 0", exp_q.size(), exp_addr_q.size());
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_write_wrap();
    int gnt_cyc, gnt_cnt, sent, last_wr_cyc;
    logic in_burst, tog;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    do_reset();
    gnt_cyc = -1; gnt_cnt = 0; sent = 0; last_wr_cyc = -1; in_burst = 1'b0; tog = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.write_req = 1'b1; bus.addr = 10'h3F8;
      end
      if (in_burst) begin
        bus.wr_valid = tog;
        tog = !tog;
        bus.wr_data = {$urandom, $urandom};
        if (bus.wr_valid && sent < BL) begin
          exp_addr_q.push_back(AW'(32'h3F8 + sent));
          exp_q.push_back(bus.wr_data);
          sent++;
          if (sent == BL) last_wr_cyc = cyc;
        end
      end
      #1;
      if (bus.write_gnt) begin
        gnt_cnt++;
        if (gnt_cyc < 0) gnt_cyc = cyc;
        bus.write_req = 1'b0;
        in_burst = 1'b1;
      end
      if (bus.mem_en) begin
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, exp_a, exp_d}) begin
          errors++;
          $display("FAIL wr_issue cyc %0d got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                   cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_a, exp_d);
        end
      end
      if (last_wr_cyc > 0 && cyc == last_wr_cyc + 1) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL wr_end_busy cyc %0d got %b want 0", cyc, bus.busy);
        end
      end
      if (last_wr_cyc > 0 && cyc >= last_wr_cyc + 6) break;
    end
    checks++;
    if (gnt_cyc != 2 || gnt_cnt != 1 || sent != BL) begin
      errors++;
      $display("FAIL wr_gnt got cyc=%0d pulses=%0d sent=%0d want cyc=2 pulses=1 sent=%0d",
               gnt_cyc, gnt_cnt, sent, BL);
    end
    checks++;
    if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL wr_leftover got %0d pending want 0", exp_q.size());
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_both_rr();
    int rd_gnt_cyc, wr_gnt_cyc, last_rd_cyc, rd_cnt, wr_cnt, early_wr, done_cyc;
    do_reset();
    rd_gnt_cyc = -1; wr_gnt_cyc = -1; last_rd_cyc = -1;
    rd_cnt = 0; wr_cnt = 0; early_wr = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 120 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.read_req = 1'b1; bus.write_req = 1'b1; bus.addr = 10'h100;
        bus.rd_ready = 1'b1; bus.wr_valid = 1'b1;
      end
      bus.wr_data = {$urandom, $urandom};
      #1;
      if (bus.read_gnt && rd_gnt_cyc < 0) begin rd_gnt_cyc = cyc; bus.read_req = 1'b0; end
      if (bus.write_gnt && wr_gnt_cyc < 0) begin wr_gnt_cyc = cyc; bus.write_req = 1'b0; end
      if (bus.rd_valid) begin rd_cnt++; last_rd_cyc = cyc; end
      if (bus.mem_en && bus.mem_we) begin
        wr_cnt++;
        if (wr_gnt_cyc < 0) early_wr++;
      end
      if (wr_cnt == BL && !bus.busy) done_cyc = cyc;
    end
    checks++;
    if (rd_gnt_cyc != 2 || wr_gnt_cyc != last_rd_cyc + 2 || last_rd_cyc < 0) begin
      errors++;
      $display("FAIL rr_order got rd_gnt=%0d wr_gnt=%0d last_rd=%0d want rd_gnt=2 wr_gnt=last_rd+2",
               rd_gnt_cyc, wr_gnt_cyc, last_rd_cyc);
    end
    checks++;
    if (rd_cnt != BL || wr_cnt != BL || early_wr != 0) begin
      errors++;
      $display("FAIL rr_counts got rd=%0d wr=%0d early_wr=%0d want %0d %0d 0",
               rd_cnt, wr_cnt, early_wr, BL, BL);
    end
    bus.rd_ready = 1'b0; bus.wr_valid = 1'b0;
  endtask

  task automatic test_rd_stall();
    int rd_cnt, done_cyc;
    logic prev_issue;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    do_reset();
    rd_cnt = 0; done_cyc = -1; prev_issue = 1'b0;
    for (int i = 0; i < BL; i++) begin
      exp_addr_q.push_back(AW'(32'h3F0 + i));
      exp_q.push_back(pat(AW'(32'h3F0 + i)));
    end
    for (int cyc = 1; cyc <= 150 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.read_req = 1'b1; bus.addr = 10'h3F0;
      end
      bus.rd_ready = cyc[0];
      #1;
      if (bus.read_gnt) bus.read_req = 1'b0;
      checks++;
      if (bus.rd_valid !== prev_issue) begin
        errors++;
        $display("FAIL rd_latency cyc %0d got rd_valid=%b want %b", cyc, bus.rd_valid, prev_issue);
      end
      if (!bus.rd_ready && bus.busy) begin
        checks++;
        if (bus.mem_en !== 1'b0) begin
          errors++;
          $display("FAIL rd_stall cyc %0d got mem_en=%b want 0", cyc, bus.mem_en);
        end
      end
      if (bus.mem_en) begin
        exp_a = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 'x;
        checks++;
        if (bus.mem_addr !== exp_a || bus.mem_we !== 1'b0) begin
          errors++;
          $display("FAIL stall_addr cyc %0d got %h want %h", cyc, bus.mem_addr, exp_a);
        end
      end
      if (bus.rd_valid) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        rd_cnt++;
        checks++;
        if (bus.rd_data !== exp_d) begin
          errors++;
          $display("FAIL stall_data cyc %0d got %h want %h", cyc, bus.rd_data, exp_d);
        end
      end
      prev_issue = bus.mem_en && !bus.mem_we;
      if (rd_cnt == BL && !bus.busy) done_cyc = cyc;
    end
    checks++;
    if (rd_cnt != BL || done_cyc < 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_done got words=%0d done=%0d left=%0d want words=%0d",
               rd_cnt, done_cyc, exp_q.size(), BL);
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic got;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    do_reset();
    @(negedge clk);
    bus.write_req = 1'b1; bus.addr = 10'h200;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk); #1;
      if (bus.write_gnt) got = 1'b1;
    end
    bus.write_req = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL rst_wr_gnt1 got none want pulse"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.wr_valid = 1'b1; bus.wr_data = {$urandom, $urandom};
      exp_addr_q.push_back(AW'(32'h200 + k));
      exp_q.push_back(bus.wr_data);
      #1;
      exp_a = exp_addr_q.pop_front();
      exp_d = exp_q.pop_front();
      checks++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, exp_a, exp_d}) begin
        errors++;
        $display("FAIL rst_wr_pre k=%0d got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                 k, bus.mem_en, bus.mem_addr, bus.mem_wdata, exp_a, exp_d);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.mem_en, bus.mem_we, bus.busy, bus.rd_valid} !== 4'b0 || dbg_state !== IDLE) begin
        errors++;
        $display("FAIL rst_abort k=%0d got en=%b we=%b busy=%b rv=%b state=%0d want 0 0 0 0 IDLE",
                 k, bus.mem_en, bus.mem_we, bus.busy, bus.rd_valid, dbg_state);
      end
    end
    @(negedge clk);
    bus.write_req = 1'b1; bus.addr = 10'h280;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk); #1;
      if (bus.write_gnt) got = 1'b1;
    end
    bus.write_req = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL rst_wr_gnt2 got none want pulse"); end
    for (int k = 0; k < BL; k++) begin
      @(negedge clk);
      bus.wr_data = {$urandom, $urandom};
      exp_addr_q.push_back(AW'(32'h280 + k));
      exp_q.push_back(bus.wr_data);
      #1;
      exp_a = exp_addr_q.pop_front();
      exp_d = exp_q.pop_front();
      checks++;
      if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {2'b11, exp_a, exp_d}) begin
        errors++;
        $display("FAIL rst_wr_post k=%0d got en=%b addr=%h data=%h want en=1 addr=%h data=%h",
                 k, bus.mem_en, bus.mem_addr, bus.mem_wdata, exp_a, exp_d);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_wr_end got busy=%b en=%b want 0 0", bus.busy, bus.mem_en);
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic test_burst_len1();
    int gq[$];
    int issues;
    logic [DW-1:0] exp_d;
    do_reset();
    issues = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus1.read_req = 1'b1; bus1.addr = 10'h055; bus1.rd_ready = 1'b1;
      end
      #1;
      if (bus1.read_gnt) begin
        gq.push_back(cyc);
        exp_q.push_back(pat(10'h055));
      end
      if (bus1.mem_en) begin
        issues++;
        checks++;
        if (bus1.mem_addr !== 10'h055 || bus1.mem_we !== 1'b0) begin
          errors++;
          $display("FAIL bl1_addr cyc %0d got %h want 055", cyc, bus1.mem_addr);
        end
      end
      if (bus1.rd_valid) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (bus1.rd_data !== exp_d) begin
          errors++;
          $display("FAIL bl1_data cyc %0d got %h want %h", cyc, bus1.rd_data, exp_d);
        end
      end
    end
    checks++;
    if (gq.size() != 4 || issues != 4) begin
      errors++;
      $display("FAIL bl1_count got grants=%0d issues=%0d want 4 4", gq.size(), issues);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gq[i] != 2 + 4 * i) begin
          errors++;
          $display("FAIL bl1_period grant %0d got cyc %0d want %0d", i, gq[i], 2 + 4 * i);
        end
      end
    end
    bus1.read_req = 1'b0; bus1.rd_ready = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    test_reset();
    test_read_burst();
    test_write_wrap();
    test_both_rr();
    test_rd_stall();
    test_reset_mid_write();
    test_burst_len1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
